// File: rtl/arm_pkg.sv
// Shared ARM decode constants: instruction field positions, opcode, condition and
// ALU command encodings, the ID/EX bundle type and the condition evaluator.
package arm_pkg;

  localparam int unsigned DW   = 32;
  localparam int unsigned NREG = 15;

  // Instruction field positions
  localparam int unsigned CondMsb   = 31;
  localparam int unsigned CondLsb   = 28;
  localparam int unsigned ModeMsb   = 27;
  localparam int unsigned ModeLsb   = 26;
  localparam int unsigned IBit      = 25;
  localparam int unsigned OpMsb     = 24;
  localparam int unsigned OpLsb     = 21;
  localparam int unsigned SBit      = 20;
  localparam int unsigned RnMsb     = 19;
  localparam int unsigned RnLsb     = 16;
  localparam int unsigned RdMsb     = 15;
  localparam int unsigned RdLsb     = 12;
  localparam int unsigned RmMsb     = 3;
  localparam int unsigned RmLsb     = 0;

  // Instruction classes (mode field)
  localparam logic [1:0] ModeDp    = 2'b00;
  localparam logic [1:0] ModeMem   = 2'b01;
  localparam logic [1:0] ModeBr    = 2'b10;

  // Data-processing opcodes
  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpEor = 4'b0001;
  localparam logic [3:0] OpSub = 4'b0010;
  localparam logic [3:0] OpAdd = 4'b0100;
  localparam logic [3:0] OpAdc = 4'b0101;
  localparam logic [3:0] OpSbc = 4'b0110;
  localparam logic [3:0] OpTst = 4'b1000;
  localparam logic [3:0] OpCmp = 4'b1010;
  localparam logic [3:0] OpOrr = 4'b1100;
  localparam logic [3:0] OpMov = 4'b1101;
  localparam logic [3:0] OpMvn = 4'b1111;

  // ALU commands
  localparam logic [3:0] ExeNop = 4'b0000;
  localparam logic [3:0] ExeMov = 4'b0001;
  localparam logic [3:0] ExeAdd = 4'b0010;
  localparam logic [3:0] ExeAdc = 4'b0011;
  localparam logic [3:0] ExeSub = 4'b0100;
  localparam logic [3:0] ExeSbc = 4'b0101;
  localparam logic [3:0] ExeAnd = 4'b0110;
  localparam logic [3:0] ExeOrr = 4'b0111;
  localparam logic [3:0] ExeEor = 4'b1000;
  localparam logic [3:0] ExeMvn = 4'b1001;

  // Condition codes
  localparam logic [3:0] CondEq = 4'b0000;
  localparam logic [3:0] CondNe = 4'b0001;
  localparam logic [3:0] CondCs = 4'b0010;
  localparam logic [3:0] CondCc = 4'b0011;
  localparam logic [3:0] CondMi = 4'b0100;
  localparam logic [3:0] CondPl = 4'b0101;
  localparam logic [3:0] CondVs = 4'b0110;
  localparam logic [3:0] CondVc = 4'b0111;
  localparam logic [3:0] CondHi = 4'b1000;
  localparam logic [3:0] CondLs = 4'b1001;
  localparam logic [3:0] CondGe = 4'b1010;
  localparam logic [3:0] CondLt = 4'b1011;
  localparam logic [3:0] CondGt = 4'b1100;
  localparam logic [3:0] CondLe = 4'b1101;
  localparam logic [3:0] CondAl = 4'b1110;

  typedef struct packed {
    logic [DW-1:0] pc;
    logic [DW-1:0] val_rn;
    logic [DW-1:0] val_rm;
    logic [11:0]   shift_operand;
    logic          imm;
    logic [23:0]   signed_imm_24;
    logic [3:0]    dest;
    logic [3:0]    exe_cmd;
    logic          mem_r_en;
    logic          mem_w_en;
    logic          wb_en;
    logic          b;
    logic          s;
  } idex_t;

  // Evaluate a condition field against {N,Z,C,V}; 1111 never executes.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, pass;
    {n, z, c, v} = nzcv;
    case (cond)
      CondEq:  pass = z;
      CondNe:  pass = ~z;
      CondCs:  pass = c;
      CondCc:  pass = ~c;
      CondMi:  pass = n;
      CondPl:  pass = ~n;
      CondVs:  pass = v;
      CondVc:  pass = ~v;
      CondHi:  pass = c & ~z;
      CondLs:  pass = ~c | z;
      CondGe:  pass = (n == v);
      CondLt:  pass = (n != v);
      CondGt:  pass = ~z & (n == v);
      CondLe:  pass = z | (n != v);
      CondAl:  pass = 1'b1;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// ID stage bus: IF/ID inputs, WB write port, hazard-unit taps and the ID/EX bundle.
interface decode_stage_if;
  import arm_pkg::*;

  logic          freeze;
  logic          flush;
  logic          hazard;
  logic [DW-1:0] pc_in;
  logic [DW-1:0] instr_in;
  logic [3:0]    status_in;
  logic          wb_en_in;
  logic [3:0]    wb_dest;
  logic [DW-1:0] wb_value;

  logic [3:0]    src1;
  logic [3:0]    src2;
  logic          two_src;

  logic [DW-1:0] pc_out;
  logic [DW-1:0] val_rn;
  logic [DW-1:0] val_rm;
  logic [11:0]   shift_operand;
  logic          imm;
  logic [23:0]   signed_imm_24;
  logic [3:0]    dest;
  logic [3:0]    exe_cmd;
  logic          mem_r_en;
  logic          mem_w_en;
  logic          wb_en;
  logic          b;
  logic          s;

  // Driver side (pipeline front end / bench)
  modport master (
    output freeze, flush, hazard, pc_in, instr_in, status_in, wb_en_in, wb_dest, wb_value,
    input  src1, src2, two_src, pc_out, val_rn, val_rm, shift_operand, imm, signed_imm_24,
           dest, exe_cmd, mem_r_en, mem_w_en, wb_en, b, s
  );

  // Decode stage side
  modport slave (
    input  freeze, flush, hazard, pc_in, instr_in, status_in, wb_en_in, wb_dest, wb_value,
    output src1, src2, two_src, pc_out, val_rn, val_rm, shift_operand, imm, signed_imm_24,
           dest, exe_cmd, mem_r_en, mem_w_en, wb_en, b, s
  );
endinterface

// File: rtl/reg_file.sv
// 15x32 architectural register file, one write port and two combinational read
// ports with write-through; address 15 always reads 0.
module reg_file
  import arm_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [3:0]    waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [3:0]    raddr1_i,
  input  logic [3:0]    raddr2_i,
  output logic [DW-1:0] rdata1_o,
  output logic [DW-1:0] rdata2_o
);

  logic [DW-1:0] regs_q [NREG];

  // Write port; R15 is not stored here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we_i && waddr_i != 4'hF) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Same-cycle WB data bypasses the array so ID sees it immediately
  function automatic logic [DW-1:0] read_port(input logic [3:0] addr);
    logic [DW-1:0] data;
    if (addr == 4'hF)                      data = '0;
    else if (we_i && addr == waddr_i)      data = wdata_i;
    else                                   data = regs_q[addr];
    return data;
  endfunction

  // Combinational read ports
  always_comb begin
    rdata1_o = read_port(raddr1_i);
    rdata2_o = read_port(raddr2_i);
  end

endmodule

// File: rtl/decode_stage.sv
// ARM ID stage: control decode, condition check, register read and the ID/EX
// pipeline register feeding EXE.
module decode_stage
  import arm_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  decode_stage_if.slave id_if
);

  logic [3:0]    cond, opcode, rn, rd, rm;
  logic [1:0]    mode;
  logic          i_bit, s_bit;
  logic [3:0]    exe_cmd_raw;
  logic          mem_r_raw, mem_w_raw, wb_raw, b_raw, s_raw;
  logic          kill;
  logic [DW-1:0] rn_val, rm_val;
  idex_t         load, idex_d, idex_q;
  logic          flush_pend_d, flush_pend_q;

  assign cond   = id_if.instr_in[CondMsb:CondLsb];
  assign mode   = id_if.instr_in[ModeMsb:ModeLsb];
  assign i_bit  = id_if.instr_in[IBit];
  assign opcode = id_if.instr_in[OpMsb:OpLsb];
  assign s_bit  = id_if.instr_in[SBit];
  assign rn     = id_if.instr_in[RnMsb:RnLsb];
  assign rd     = id_if.instr_in[RdMsb:RdLsb];
  assign rm     = id_if.instr_in[RmMsb:RmLsb];

  // Raw control decode, before condition/hazard masking
  always_comb begin
    exe_cmd_raw = ExeNop;
    mem_r_raw   = 1'b0;
    mem_w_raw   = 1'b0;
    wb_raw      = 1'b0;
    b_raw       = 1'b0;
    s_raw       = 1'b0;
    unique case (mode)
      ModeDp: begin
        s_raw  = s_bit;
        wb_raw = 1'b1;
        case (opcode)
          OpMov:   exe_cmd_raw = ExeMov;
          OpMvn:   exe_cmd_raw = ExeMvn;
          OpAdd:   exe_cmd_raw = ExeAdd;
          OpAdc:   exe_cmd_raw = ExeAdc;
          OpSub:   exe_cmd_raw = ExeSub;
          OpSbc:   exe_cmd_raw = ExeSbc;
          OpAnd:   exe_cmd_raw = ExeAnd;
          OpOrr:   exe_cmd_raw = ExeOrr;
          OpEor:   exe_cmd_raw = ExeEor;
          OpCmp: begin
            exe_cmd_raw = ExeSub;
            wb_raw      = 1'b0;
          end
          OpTst: begin
            exe_cmd_raw = ExeAnd;
            wb_raw      = 1'b0;
          end
          default: exe_cmd_raw = ExeNop;
        endcase
      end
      ModeMem: begin
        exe_cmd_raw = ExeAdd;
        if (s_bit) begin
          mem_r_raw = 1'b1;
          wb_raw    = 1'b1;
        end else begin
          mem_w_raw = 1'b1;
        end
      end
      ModeBr:  b_raw = 1'b1;
      default: ;
    endcase
  end

  // Hazard-unit taps use the unmasked decode; masking them would create a loop
  assign id_if.src1    = rn;
  assign id_if.src2    = mem_w_raw ? rd : rm;
  assign id_if.two_src = ~i_bit | mem_w_raw;

  assign kill = id_if.hazard | ~cond_pass(cond, id_if.status_in);

  reg_file u_reg_file (
    .clk      (clk),
    .rst      (rst),
    .we_i     (id_if.wb_en_in),
    .waddr_i  (id_if.wb_dest),
    .wdata_i  (id_if.wb_value),
    .raddr1_i (rn),
    .raddr2_i (id_if.src2),
    .rdata1_o (rn_val),
    .rdata2_o (rm_val)
  );

  // Bundle that a normal (unfrozen, unflushed) edge loads
  always_comb begin
    load               = '0;
    load.pc            = id_if.pc_in;
    load.val_rn        = rn_val;
    load.val_rm        = rm_val;
    load.shift_operand = id_if.instr_in[11:0];
    load.imm           = i_bit;
    load.signed_imm_24 = id_if.instr_in[23:0];
    load.dest          = rd;
    if (!kill) begin
      load.exe_cmd  = exe_cmd_raw;
      load.mem_r_en = mem_r_raw;
      load.mem_w_en = mem_w_raw;
      load.wb_en    = wb_raw;
      load.b        = b_raw;
      load.s        = s_raw;
    end
  end

  // Freeze holds; a flush seen while frozen is remembered until the first free edge
  always_comb begin
    idex_d       = idex_q;
    flush_pend_d = flush_pend_q;
    if (id_if.freeze) begin
      flush_pend_d = flush_pend_q | id_if.flush;
    end else begin
      flush_pend_d = 1'b0;
      idex_d       = (id_if.flush || flush_pend_q) ? '0 : load;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_q       <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      idex_q       <= idex_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign id_if.pc_out        = idex_q.pc;
  assign id_if.val_rn        = idex_q.val_rn;
  assign id_if.val_rm        = idex_q.val_rm;
  assign id_if.shift_operand = idex_q.shift_operand;
  assign id_if.imm           = idex_q.imm;
  assign id_if.signed_imm_24 = idex_q.signed_imm_24;
  assign id_if.dest          = idex_q.dest;
  assign id_if.exe_cmd       = idex_q.exe_cmd;
  assign id_if.mem_r_en      = idex_q.mem_r_en;
  assign id_if.mem_w_en      = idex_q.mem_w_en;
  assign id_if.wb_en         = idex_q.wb_en;
  assign id_if.b             = idex_q.b;
  assign id_if.s             = idex_q.s;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized bench for decode_stage against an instruction-level reference model,
// plus directed scenarios for MOV, conditional ADD, write-through, BLT and STR/freeze.
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] val_rn;
    logic [31:0] val_rm;
    logic [11:0] shift_operand;
    logic        imm;
    logic [23:0] signed_imm_24;
    logic [3:0]  dest;
    logic [3:0]  exe_cmd;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        wb_en;
    logic        b;
    logic        s;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decode_stage_if bus ();

  decode_stage dut (
    .clk   (clk),
    .rst   (rst),
    .id_if (bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference state
  logic [31:0] m_regs [15];
  exp_t        m_q;
  bit          m_pend;
  logic [3:0]  dp_ops [11];
  logic [3:0]  dp_cmd [16];
  logic [31:0] last_pc;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t observed();
    exp_t o;
    o.pc = bus.pc_out;               o.val_rn = bus.val_rn;   o.val_rm = bus.val_rm;
    o.shift_operand = bus.shift_operand; o.imm = bus.imm;
    o.signed_imm_24 = bus.signed_imm_24; o.dest = bus.dest;   o.exe_cmd = bus.exe_cmd;
    o.mem_r_en = bus.mem_r_en;       o.mem_w_en = bus.mem_w_en;
    o.wb_en = bus.wb_en;             o.b = bus.b;             o.s = bus.s;
    return o;
  endfunction

  function automatic bit ref_cond(input logic [3:0] c, input logic [3:0] st);
    bit n, z, cy, v;
    n = st[3]; z = st[2]; cy = st[1]; v = st[0];
    case (c)
      0: return z;         1: return !z;        2: return cy;        3: return !cy;
      4: return n;         5: return !n;        6: return v;         7: return !v;
      8: return cy && !z;  9: return !cy || z;  10: return n == v;   11: return n != v;
      12: return !z && n == v;                  13: return z || n != v;
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_read(input logic [3:0] a);
    if (a == 4'd15) return 32'd0;
    if (bus.wb_en_in && bus.wb_dest == a) return bus.wb_value;
    return m_regs[a];
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    ins = $urandom;
    ins[31:28] = 4'($urandom_range(0, 15));
    if (ins[27:26] == 2'b00) ins[24:21] = dp_ops[$urandom_range(0, 10)];
    return ins;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 15; i++) m_regs[i] = '0;
    m_q    = '0;
    m_pend = 0;
  endtask

  task automatic set_in(input logic [31:0] ins, input logic [3:0] st);
    last_pc       = $urandom & 32'hFFFF_FFFC;
    bus.pc_in     = last_pc;
    bus.instr_in  = ins;
    bus.status_in = st;
    bus.hazard    = 1'b0;
    bus.freeze    = 1'b0;
    bus.flush     = 1'b0;
    bus.wb_en_in  = 1'b0;
    bus.wb_dest   = 4'd0;
    bus.wb_value  = '0;
  endtask

  // One cycle: check hazard taps, predict the edge, then compare the ID/EX bundle
  task automatic step();
    exp_t        nx;
    logic [31:0] ins;
    bit          is_str;
    ins = bus.instr_in;
    #1;
    is_str = (ins[27:26] == 2'b01) && !ins[20];
    check("src1", 160'(bus.src1), 160'(ins[19:16]));
    check("src2", 160'(bus.src2), 160'(is_str ? ins[15:12] : ins[3:0]));
    check("two_src", 160'(bus.two_src), 160'(!ins[25] || is_str));
    nx               = '0;
    nx.pc            = bus.pc_in;
    nx.val_rn        = ref_read(ins[19:16]);
    nx.val_rm        = ref_read(is_str ? ins[15:12] : ins[3:0]);
    nx.shift_operand = ins[11:0];
    nx.imm           = ins[25];
    nx.signed_imm_24 = ins[23:0];
    nx.dest          = ins[15:12];
    case (ins[27:26])
      2'b00: begin
        nx.exe_cmd = dp_cmd[ins[24:21]];
        nx.wb_en   = !(ins[24:21] == 4'b1010 || ins[24:21] == 4'b1000);
        nx.s       = ins[20];
      end
      2'b01: begin
        nx.exe_cmd = 4'b0010;
        if (ins[20]) begin nx.mem_r_en = 1; nx.wb_en = 1; end
        else nx.mem_w_en = 1;
      end
      2'b10: nx.b = 1;
      default: ;
    endcase
    if (bus.hazard || !ref_cond(ins[31:28], bus.status_in)) begin
      nx.exe_cmd = 0; nx.mem_r_en = 0; nx.mem_w_en = 0; nx.wb_en = 0; nx.b = 0; nx.s = 0;
    end
    @(posedge clk);
    if (bus.freeze) m_pend = m_pend || bus.flush;
    else begin
      m_q    = (bus.flush || m_pend) ? exp_t'(0) : nx;
      m_pend = 0;
    end
    if (bus.wb_en_in && bus.wb_dest != 4'd15) m_regs[bus.wb_dest] = bus.wb_value;
    #1;
    check("idex", 160'(observed()), 160'(m_q));
  endtask

  // Asynchronous reset in the middle of a cycle while an instruction is loading
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst_async", 160'(observed()), 160'd0);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [31:0] pc_str;
    dp_ops = '{4'b1101, 4'b1111, 4'b0100, 4'b0101, 4'b0010, 4'b0110,
               4'b0000, 4'b1100, 4'b0001, 4'b1010, 4'b1000};
    for (int i = 0; i < 16; i++) dp_cmd[i] = 4'b0000;
    dp_cmd[4'b1101] = 4'b0001; dp_cmd[4'b1111] = 4'b1001; dp_cmd[4'b0100] = 4'b0010;
    dp_cmd[4'b0101] = 4'b0011; dp_cmd[4'b0010] = 4'b0100; dp_cmd[4'b0110] = 4'b0101;
    dp_cmd[4'b0000] = 4'b0110; dp_cmd[4'b1100] = 4'b0111; dp_cmd[4'b0001] = 4'b1000;
    dp_cmd[4'b1010] = 4'b0100; dp_cmd[4'b1000] = 4'b0110;
    model_reset();
    set_in(32'hE3A00014, 4'b0000);
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 160'(observed()), 160'd0);
    rst = 1'b0;

    // MOV R0,#20
    set_in(32'hE3A00014, 4'b0000);
    step();
    check("mov.exe_cmd", 160'(bus.exe_cmd), 160'(4'b0001));
    check("mov.wb_en", 160'(bus.wb_en), 160'd1);
    check("mov.imm", 160'(bus.imm), 160'd1);
    check("mov.dest", 160'(bus.dest), 160'd0);
    check("mov.shift", 160'(bus.shift_operand), 160'(12'h014));

    // ADDNE, Z set then clear
    set_in(32'h10811001, 4'b0100);
    step();
    check("addne_z1.exe_cmd", 160'(bus.exe_cmd), 160'd0);
    check("addne_z1.wb_en", 160'(bus.wb_en), 160'd0);
    set_in(32'h10811001, 4'b0000);
    step();
    check("addne_z0.exe_cmd", 160'(bus.exe_cmd), 160'(4'b0010));
    check("addne_z0.wb_en", 160'(bus.wb_en), 160'd1);

    // WB R1=4096 while reading R1, then R15
    set_in(32'hE0811002, 4'b0000);
    bus.wb_en_in = 1'b1; bus.wb_dest = 4'd1; bus.wb_value = 32'd4096;
    step();
    check("wt.val_rn", 160'(bus.val_rn), 160'd4096);
    set_in(32'hE08F0001, 4'b0000);
    step();
    check("r15.val_rn", 160'(bus.val_rn), 160'd0);
    check("r1_stored.val_rm", 160'(bus.val_rm), 160'd4096);

    // BLT with N!=V then N==V
    set_in(32'hBAFFFFF7, 4'b1000);
    step();
    check("blt_taken.b", 160'(bus.b), 160'd1);
    check("blt.simm", 160'(bus.signed_imm_24), 160'(24'hFFFFF7));
    set_in(32'hBAFFFFF7, 4'b1001);
    step();
    check("blt_not.b", 160'(bus.b), 160'd0);

    // STR, then freeze+flush holds, release gives a bubble
    set_in(32'hE5801000, 4'b0000);
    pc_str = last_pc;
    #1;
    check("str.src2", 160'(bus.src2), 160'd1);
    check("str.two_src", 160'(bus.two_src), 160'd1);
    step();
    check("str.mem_w_en", 160'(bus.mem_w_en), 160'd1);
    set_in(32'hE3A00014, 4'b0000);
    bus.freeze = 1'b1; bus.flush = 1'b1;
    step();
    step();
    check("frz.mem_w_en", 160'(bus.mem_w_en), 160'd1);
    check("frz.pc", 160'(bus.pc_out), 160'(pc_str));
    bus.freeze = 1'b0;
    step();
    check("unfrz.bubble", 160'(observed()), 160'd0);
    // Flush dropped together with freeze still bubbles
    set_in(32'hE3A00014, 4'b0000);
    step();
    bus.freeze = 1'b1; bus.flush = 1'b1;
    step();
    bus.freeze = 1'b0; bus.flush = 1'b0;
    step();
    check("pend.bubble", 160'(bus.pc_out), 160'd0);

    // Reset mid-load clears pipeline and register file
    set_in(32'hE0811002, 4'b0000);
    async_reset();
    step();
    check("rst.rf_r1", 160'(bus.val_rn), 160'd0);

    // Randomized traffic with an occasional reset
    for (int n = 0; n < 600; n++) begin
      bus.pc_in     = $urandom;
      bus.instr_in  = rand_instr();
      bus.status_in = 4'($urandom);
      bus.hazard    = ($urandom_range(0, 6) == 0);
      bus.freeze    = ($urandom_range(0, 7) == 0);
      bus.flush     = ($urandom_range(0, 7) == 0);
      bus.wb_en_in  = 1'($urandom);
      bus.wb_dest   = 4'($urandom);
      bus.wb_value  = $urandom;
      if (n % 200 == 199) async_reset();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
